jt34061_vtimer: RTL
===================

# jt34061_vtimer

Video timing core for the JT34061 video system controller. It runs the horizontal and vertical counters at pixel rate and decodes them against the timing registers held in the controller's register file. From that it produces sync, blanking, the vertical interrupt, the display row address and a row-load strobe. It sits directly downstream of the host register file, which drives its timing inputs, and upstream of the video memory shift-register transfer logic.

## Interface
- W, 12, width of every counter, timing register and the display address
- rst  in  1  asynchronous reset, active-high
- clk  in  1  system clock
- pxl_cen  in  1  pixel clock enable; all counting is qualified by it
- hs_end, hb_end, hb_start, h_total  in  W each  horizontal timing registers
- vs_end, vb_end, vb_start, v_total  in  W each  vertical timing registers
- v_int  in  W  line that raises the vertical interrupt
- disp_start  in  W  display start row address
- int_ack  in  1  interrupt clear, one clk pulse from the register file
- h_cnt, v_cnt  out  W each  current counters
- hs, vs  out  1 each  sync, active-high
- lhbl, lvbl  out  1 each  active-low blanking (1 = visible)
- int_n  out  1  vertical interrupt, active-low
- disp_addr  out  W  current display row address
- row_ld  out  1  row transfer strobe, one clk wide

## Operation
- Horizontal counting happens on pxl_cen.
  - If h_cnt >= h_total, h_cnt becomes 0 ("line wrap"). Otherwise h_cnt increments.
  - Using >= means a shrunk h_total takes effect on the next pxl_cen.
- Vertical counting happens only on a line wrap.
  - If v_cnt >= v_total, v_cnt becomes 0. Otherwise v_cnt increments.
- Decode is applied to the new counter values in the same clk, so outputs stay coincident with the counters:
  - hs = h_cnt < hs_end
  - lhbl = (h_cnt >= hb_end) && (h_cnt < hb_start)
  - vs = v_cnt < vs_end
  - lvbl = (v_cnt >= vb_end) && (v_cnt < vb_start)
- Timing register changes are compared live. There is no shadowing.
- disp_addr is updated on a line wrap:
  - If the new v_cnt == vb_end, disp_addr <= disp_start.
  - Else if the new lvbl is 1, disp_addr <= disp_addr + 1, wrapping modulo 2^W.
  - Otherwise disp_addr holds.
- row_ld is a one-clk pulse on the pxl_cen where the new h_cnt == hb_end and the current lvbl is 1.
- Interrupt:
  - On a line wrap whose new v_cnt == v_int, int_n <= 0.
  - int_ack sets int_n <= 1.
  - If both happen in the same clk, the set wins (int_n = 0).
- Degenerate settings:
  - h_total = 0: every pxl_cen is a line wrap.
  - hb_end >= hb_start: lhbl stays 0. The same rule applies to lvbl.

## Timing
- Reset values: h_cnt = 0, v_cnt = 0, hs = 0, vs = 0, lhbl = 0, lvbl = 0, int_n = 1, disp_addr = 0, row_ld = 0.
- The first pxl_cen after reset moves h_cnt to 1 and decodes the outputs.
- Latency: zero pxl_cen between a counter value and its decode. Both are registered in the same clk.
- Period: one line is h_total+1 pxl_cen; one frame is (v_total+1) lines.
- row_ld and int_n edges are clk-aligned with the pxl_cen that caused them.
- Reset during operation clears everything immediately, including a pending interrupt.
- int_ack while int_n = 1 has no effect.

## Configuration
- JT34061_VINT_EN defined: the interrupt logic is present as described above.
- JT34061_VINT_EN undefined: int_n is tied to 1, int_ack and v_int are ignored, and no interrupt flop is synthesised.

## Structure
- Package jt34061_pkg holds:
  - the register index constants (HS_END = 0 … XY_OFFSET = 14);
  - the reset defaults (H_TOTAL = 12'h200, V_TOTAL = 12'h100, etc.);
  - the W localparam.
- Sub-module jt34061_cnt is one axis:
  - a counter with wrap at a total value, sync and blank decode, and a wrap output;
  - instantiated twice, horizontal enabled by pxl_cen and vertical enabled by the horizontal wrap.
- Top-level logic in jt34061_vtimer is the display address, row_ld and the interrupt.

## Test plan
Common setup for all scenarios: hs_end = 2, hb_end = 4, hb_start = 12, h_total = 15, vs_end = 1, vb_end = 2, vb_start = 8, v_total = 9, pxl_cen every clk.
- Line timing: run one line. Expect hs = 1 for h_cnt 0–1, lhbl = 1 for h_cnt 4–11, wrap after h_cnt = 15, 16 pxl_cen per line.
- Frame timing: run 2 frames.
  - vs = 1 only on line 0; lvbl = 1 on lines 2–7.
  - 160 pxl_cen per frame; v_cnt wraps 9 → 0.
- Display address: disp_start = 12'h0FE.
  - Line 2 gives disp_addr 0FE; line 3 gives 0FF; line 4 gives 100.
  - row_ld pulses exactly 6 times per frame.
- Interrupt: v_int = 5.
  - int_n falls on the line wrap into line 5.
  - int_ack at the same clk as the next frame's event leaves int_n = 0; a lone int_ack then gives int_n = 1.
- Live change: set h_total = 7 while h_cnt = 10. Expect the next pxl_cen to give h_cnt = 0 and v_cnt + 1, then 8-pixel lines.
- Reset mid-frame: assert rst at v_cnt = 6 with int_n = 0. Expect all outputs at reset values in the same clk, and int_n = 1.

Source files
------------

// File: rtl/jt34061_pkg.sv
// Shared constants for the JT34061 video timing slice: data width,
// register file indices and the timing register reset defaults.
package jt34061_pkg;

  localparam int W = 12;

  typedef enum logic [3:0] {
    HS_END      = 4'd0,
    HB_END      = 4'd1,
    HB_START    = 4'd2,
    H_TOTAL     = 4'd3,
    VS_END      = 4'd4,
    VB_END      = 4'd5,
    VB_START    = 4'd6,
    V_TOTAL     = 4'd7,
    DISP_UPDATE = 4'd8,
    DISP_START  = 4'd9,
    V_INT       = 4'd10,
    CONTROL1    = 4'd11,
    CONTROL2    = 4'd12,
    STATUS      = 4'd13,
    XY_OFFSET   = 4'd14
  } reg_idx_e;

  localparam logic [W-1:0] RST_HS_END     = 12'h010;
  localparam logic [W-1:0] RST_HB_END     = 12'h020;
  localparam logic [W-1:0] RST_HB_START   = 12'h1E0;
  localparam logic [W-1:0] RST_H_TOTAL    = 12'h200;
  localparam logic [W-1:0] RST_VS_END     = 12'h004;
  localparam logic [W-1:0] RST_VB_END     = 12'h010;
  localparam logic [W-1:0] RST_VB_START   = 12'h0F0;
  localparam logic [W-1:0] RST_V_TOTAL    = 12'h100;
  localparam logic [W-1:0] RST_V_INT      = 12'h0F0;
  localparam logic [W-1:0] RST_DISP_START = 12'h000;

  // Visible window is [lo, hi); an empty or inverted window never opens.
  function automatic logic in_window(input logic [W-1:0] cnt,
                                     input logic [W-1:0] lo,
                                     input logic [W-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/jt34061_vtimer_if.sv
// Timing register inputs and decoded video timing outputs of jt34061_vtimer.
// master = register file side, slave = the timing core.
interface jt34061_vtimer_if;
  import jt34061_pkg::*;

  logic         pxl_cen;
  logic [W-1:0] hs_end;
  logic [W-1:0] hb_end;
  logic [W-1:0] hb_start;
  logic [W-1:0] h_total;
  logic [W-1:0] vs_end;
  logic [W-1:0] vb_end;
  logic [W-1:0] vb_start;
  logic [W-1:0] v_total;
  logic [W-1:0] v_int;
  logic [W-1:0] disp_start;
  logic         int_ack;

  logic [W-1:0] h_cnt;
  logic [W-1:0] v_cnt;
  logic         hs;
  logic         vs;
  logic         lhbl;
  logic         lvbl;
  logic         int_n;
  logic [W-1:0] disp_addr;
  logic         row_ld;

  modport master (
    output pxl_cen, hs_end, hb_end, hb_start, h_total,
           vs_end, vb_end, vb_start, v_total, v_int, disp_start, int_ack,
    input  h_cnt, v_cnt, hs, vs, lhbl, lvbl, int_n, disp_addr, row_ld
  );

  modport slave (
    input  pxl_cen, hs_end, hb_end, hb_start, h_total,
           vs_end, vb_end, vb_start, v_total, v_int, disp_start, int_ack,
    output h_cnt, v_cnt, hs, vs, lhbl, lvbl, int_n, disp_addr, row_ld
  );

endinterface

// File: rtl/jt34061_cnt.sv
// One timing axis: counter wrapping at total, with sync and blanking decoded
// from the new count in the same clk. Next-state values are exported for the top.
module jt34061_cnt
  import jt34061_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] total_i,
  input  logic [W-1:0] sync_end_i,
  input  logic [W-1:0] blk_end_i,
  input  logic [W-1:0] blk_start_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_nxt_o,
  output logic         sync_o,
  output logic         blank_n_o,
  output logic         blank_n_nxt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sync_q, sync_d;
  logic         blank_n_q, blank_n_d;

  always_comb begin
    cnt_d     = cnt_q;
    sync_d    = sync_q;
    blank_n_d = blank_n_q;
    // >= so that a total shrunk below the current count wraps at once
    wrap_o    = en_i && (cnt_q >= total_i);
    if (en_i) begin
      cnt_d     = wrap_o ? '0 : cnt_q + 1'b1;
      sync_d    = cnt_d < sync_end_i;
      blank_n_d = in_window(cnt_d, blk_end_i, blk_start_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      sync_q    <= 1'b0;
      blank_n_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sync_q    <= sync_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign cnt_o         = cnt_q;
  assign cnt_nxt_o     = cnt_d;
  assign sync_o        = sync_q;
  assign blank_n_o     = blank_n_q;
  assign blank_n_nxt_o = blank_n_d;

endmodule

// File: rtl/jt34061_vtimer.sv
// JT34061 video timing core: H/V counters, sync/blank, display row address,
// row_ld strobe and vertical interrupt (interrupt present only with JT34061_VINT_EN).
module jt34061_vtimer
  import jt34061_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  jt34061_vtimer_if.slave  vt_if
);

  logic [W-1:0] h_nxt, v_nxt;
  logic         h_wrap, v_wrap_unused;
  logic         lhbl_nxt_unused, lvbl_nxt;

  jt34061_cnt u_hcnt (
    .clk          (clk),
    .rst          (rst),
    .en_i         (vt_if.pxl_cen),
    .total_i      (vt_if.h_total),
    .sync_end_i   (vt_if.hs_end),
    .blk_end_i    (vt_if.hb_end),
    .blk_start_i  (vt_if.hb_start),
    .cnt_o        (vt_if.h_cnt),
    .cnt_nxt_o    (h_nxt),
    .sync_o       (vt_if.hs),
    .blank_n_o    (vt_if.lhbl),
    .blank_n_nxt_o(lhbl_nxt_unused),
    .wrap_o       (h_wrap)
  );

  jt34061_cnt u_vcnt (
    .clk          (clk),
    .rst          (rst),
    .en_i         (h_wrap),
    .total_i      (vt_if.v_total),
    .sync_end_i   (vt_if.vs_end),
    .blk_end_i    (vt_if.vb_end),
    .blk_start_i  (vt_if.vb_start),
    .cnt_o        (vt_if.v_cnt),
    .cnt_nxt_o    (v_nxt),
    .sync_o       (vt_if.vs),
    .blank_n_o    (vt_if.lvbl),
    .blank_n_nxt_o(lvbl_nxt),
    .wrap_o       (v_wrap_unused)
  );

  logic [W-1:0] disp_q, disp_d;
  logic         row_ld_q, row_ld_d;

  always_comb begin
    disp_d   = disp_q;
    row_ld_d = vt_if.pxl_cen && (h_nxt == vt_if.hb_end) && vt_if.lvbl;
    if (h_wrap) begin
      if (v_nxt == vt_if.vb_end)
        disp_d = vt_if.disp_start;
      else if (lvbl_nxt)
        disp_d = disp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q   <= '0;
      row_ld_q <= 1'b0;
    end else begin
      disp_q   <= disp_d;
      row_ld_q <= row_ld_d;
    end
  end

  assign vt_if.disp_addr = disp_q;
  assign vt_if.row_ld    = row_ld_q;

`ifdef JT34061_VINT_EN
  logic int_n_q, int_n_d;

  always_comb begin
    int_n_d = int_n_q;
    if (vt_if.int_ack)
      int_n_d = 1'b1;
    // A new interrupt event beats a simultaneous acknowledge
    if (h_wrap && (v_nxt == vt_if.v_int))
      int_n_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) int_n_q <= 1'b1;
    else     int_n_q <= int_n_d;
  end

  assign vt_if.int_n = int_n_q;
`else
  logic unused_int;
  assign unused_int  = ^{vt_if.v_int, vt_if.int_ack};
  assign vt_if.int_n = 1'b1;
`endif

endmodule
